exception_unit: RTL

//  Exception/interrupt state holder sitting directly downstream of the decode controller.

---
 rtl/exception_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/exception_unit.sv
// Exception/interrupt state holder downstream of the decode controller: latches
// return state, steers the PC mux and owns the external-IRQ synchronizer/pending latch.
module exception_unit #(
    parameter int          N        = 64,
    parameter logic [N-1:0] VECTOR  = 64'hD8,
    parameter logic [3:0]  IRQ_CODE = 4'h1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         irq_in,
    input  logic         Exc,
    input  logic         ERet,
    input  logic         ExtIAck,
    input  logic [3:0]   EStatus,
    input  logic [N-1:0] PC,
    input  logic [N-1:0] NextPC,
    output logic         ExtIRQ,
    output logic         ExcAck,
    output logic         EProc,
    output logic [N-1:0] ExcVector,
    output logic         ERetSel,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic [N-1:0] ERR,
    output logic         InHandler,
    output logic         DoubleFlt
);

    typedef enum logic {IDLE = 1'b0, HANDLER = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] elr_q, elr_d;
    logic [N-1:0] err_q, err_d;
    logic [3:0]   esr_q, esr_d;
    logic         ack_q, ack_d;
    logic         dbl_q, dbl_d;
    logic         pend_q, pend_d;
    logic         sync1_q, sync2_q, sync3_q;
    logic         irq_rise;

    // sync3_q only remembers the previous synchronized level for edge detection
    assign irq_rise = sync2_q & ~sync3_q;

    always_comb begin
        state_d = state_q;
        elr_d   = elr_q;
        err_d   = err_q;
        esr_d   = esr_q;
        ack_d   = 1'b0;
        dbl_d   = dbl_q;
        pend_d  = pend_q;

        if (Exc) begin
            if (state_q == IDLE) begin
                elr_d   = (EStatus == IRQ_CODE) ? NextPC : PC;
                err_d   = PC;
                esr_d   = EStatus;
                ack_d   = 1'b1;
                state_d = HANDLER;
            end else begin
                esr_d = 4'hF;
                dbl_d = 1'b1;
            end
        end else if (ERet && state_q == HANDLER) begin
            state_d = IDLE;
        end

        // A new edge outranks an acknowledge landing in the same cycle
        if (irq_rise) begin
            pend_d = 1'b1;
        end else if (ExtIAck) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            elr_q   <= '0;
            err_q   <= '0;
            esr_q   <= '0;
            ack_q   <= 1'b0;
            dbl_q   <= 1'b0;
            pend_q  <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elr_q   <= elr_d;
            err_q   <= err_d;
            esr_q   <= esr_d;
            ack_q   <= ack_d;
            dbl_q   <= dbl_d;
            pend_q  <= pend_d;
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign ExtIRQ    = pend_q & (state_q == IDLE);
    assign ExcAck    = ack_q;
    assign EProc     = Exc;
    assign ExcVector = VECTOR;
    assign ERetSel   = ERet & ~Exc & (state_q == HANDLER);
    assign ELR       = elr_q;
    assign ESR       = esr_q;
    assign ERR       = err_q;
    assign InHandler = (state_q == HANDLER);
    assign DoubleFlt = dbl_q;

endmodule
